// File: rtl/step_ramp_gen.sv
// Step/dir pulse generator with a trapezoidal period ramp (one instance per axis).
// Optional STEP_POSITION_EN adds a signed, wrapping position output.
module step_ramp_gen #(
    parameter int CNT_W     = 20,
    parameter int POS_W     = 32,
    parameter int PULSE_W   = 50,
    parameter int RAMP_STEP = 100,
    parameter int DIR_SETUP = 250
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             direction,
    input  logic [POS_W-1:0] target_steps,
    input  logic [CNT_W-1:0] period_start,
    input  logic [CNT_W-1:0] period_min,
    output logic             step_out,
    output logic             dir,
    output logic             busy,
    output logic             done,
`ifdef STEP_POSITION_EN
    output logic [POS_W-1:0] position,
`endif
    output logic [POS_W-1:0] steps_done
);

    localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2 * PULSE_W);
    localparam logic [CNT_W:0]   RAMP_W     = (CNT_W+1)'(RAMP_STEP);
    localparam logic [CNT_W:0]   PULSE_LEN  = (CNT_W+1)'(PULSE_W);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP - 1);

    typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;
    state_t state, next_state;

    logic [POS_W-1:0] target_r, accel_cnt;
    logic [CNT_W-1:0] period, ps_eff, pm_eff, pcnt;
    logic             stop_req;

    logic [CNT_W-1:0] pm_in, ps_in, period_up, period_dn;
    logic [CNT_W:0]   up_sum;
    logic [POS_W-1:0] sd_next, tgt_stop, tgt_eff, rem;
    logic             step_end, setup_end, pulse_start;

    always_comb begin
        pm_in     = (period_min > MIN_PERIOD) ? period_min : MIN_PERIOD;
        ps_in     = (period_start > pm_in) ? period_start : pm_in;
        step_end  = (state == RUN) && (pcnt == period - 1'b1);
        setup_end = (state == SETUP) && !stop && (pcnt == SETUP_LAST);
        sd_next   = steps_done + 1'b1;
        tgt_stop  = sd_next + accel_cnt;
        // A pending stop only ever shortens the move to "decelerate from here".
        tgt_eff   = ((stop || stop_req) && (tgt_stop < target_r)) ? tgt_stop : target_r;
        rem       = tgt_eff - sd_next;
        up_sum    = {1'b0, period} + RAMP_W;
        period_up = (up_sum > {1'b0, ps_eff}) ? ps_eff : up_sum[CNT_W-1:0];
        period_dn = ({1'b0, period} > ({1'b0, pm_eff} + RAMP_W)) ?
                    (period - RAMP_W[CNT_W-1:0]) : pm_eff;
        pulse_start = setup_end || (step_end && (rem != '0));
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && (target_steps != '0)) next_state = SETUP;
            SETUP:   if (stop) next_state = IDLE;
                     else if (setup_end) next_state = RUN;
            RUN:     if (step_end && (rem == '0)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            step_out   <= 1'b0;
            dir        <= 1'b0;
            done       <= 1'b0;
            steps_done <= '0;
            target_r   <= '0;
            accel_cnt  <= '0;
            period     <= '0;
            ps_eff     <= '0;
            pm_eff     <= '0;
            pcnt       <= '0;
            stop_req   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    stop_req <= 1'b0;
                    if (start) begin
                        steps_done <= '0;
                        target_r   <= target_steps;
                        ps_eff     <= ps_in;
                        pm_eff     <= pm_in;
                        period     <= ps_in;
                        accel_cnt  <= '0;
                        pcnt       <= '0;
                        if (target_steps == '0) done <= 1'b1;
                        else                    dir  <= direction;
                    end
                end
                SETUP: begin
                    if (stop)           done <= 1'b1;
                    else if (setup_end) pcnt <= '0;
                    else                pcnt <= pcnt + 1'b1;
                    if (setup_end) step_out <= 1'b1;
                end
                RUN: begin
                    if (stop) stop_req <= 1'b1;
                    if (step_end) begin
                        steps_done <= sd_next;
                        target_r   <= tgt_eff;
                        pcnt       <= '0;
                        step_out   <= pulse_start;
                        if (rem == '0) begin
                            done <= 1'b1;
                        end else if (rem <= accel_cnt) begin
                            period    <= period_up;
                            accel_cnt <= (accel_cnt == '0) ? '0 : accel_cnt - 1'b1;
                        end else if (period > pm_eff) begin
                            period    <= period_dn;
                            accel_cnt <= accel_cnt + 1'b1;
                        end
                    end else begin
                        pcnt     <= pcnt + 1'b1;
                        step_out <= (({1'b0, pcnt} + 1'b1) < PULSE_LEN);
                    end
                end
                default: step_out <= 1'b0;
            endcase
        end
    end

`ifdef STEP_POSITION_EN
    always_ff @(posedge clk) begin
        if (rst)              position <= '0;
        else if (pulse_start) position <= dir ? position + 1'b1 : position - 1'b1;
    end
`endif

endmodule

// File: tb/tb_step_ramp_gen.sv
// Self-checking bench for step_ramp_gen: directed profile cases plus random moves
// checked against a per-step profile model.
module tb_step_ramp_gen;

    localparam int CNT_W = 20, POS_W = 32, PW = 4, RS = 10, DS = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0, stop = 1'b0, direction = 1'b0;
    logic [POS_W-1:0] target_steps = '0;
    logic [CNT_W-1:0] period_start = '0, period_min = '0;
    logic             step_out, dir, busy, done;
    logic [POS_W-1:0] steps_done;
`ifdef STEP_POSITION_EN
    logic [POS_W-1:0] position;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    step_ramp_gen #(.CNT_W(CNT_W), .POS_W(POS_W), .PULSE_W(PW), .RAMP_STEP(RS), .DIR_SETUP(DS)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .direction(direction),
        .target_steps(target_steps), .period_start(period_start), .period_min(period_min),
        .step_out(step_out), .dir(dir), .busy(busy), .done(done),
`ifdef STEP_POSITION_EN
        .position(position),
`endif
        .steps_done(steps_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Step periods of a move, one entry per pulse, from the clamp and ramp rules.
    function automatic void model(input int n, input int ps, input int pm, input int stopn);
        int pme, pse, p, acc, tgt;
        exp_q.delete();
        pme = (pm < 2 * PW) ? 2 * PW : pm;
        pse = (ps < pme) ? pme : ps;
        p = pse; acc = 0; tgt = n;
        for (int i = 1; i <= n; i++) begin
            exp_q.push_back(p);
            if (i == stopn && i + acc < tgt) tgt = i + acc;
            if (tgt == i) break;
            if (tgt - i <= acc) begin
                p = (p + RS > pse) ? pse : p + RS;
                acc--;
            end else if (p > pme) begin
                p = (p - RS < pme) ? pme : p - RS;
                acc++;
            end
        end
    endfunction

    // t counts cycles after the accepting edge: sample t reflects cycle k+t.
    task automatic run_move(input int n, input int ps, input int pm, input logic d,
                            input int stopn, input bit busy_start, input bit with_stop);
        int rises[$];
        int t, tdone, ndone, hcnt;
        logic prev;
        bit finished;
        model(n, ps, pm, stopn);
        @(negedge clk);
        direction = d; target_steps = POS_W'(n);
        period_start = CNT_W'(ps); period_min = CNT_W'(pm);
        start = 1'b1; stop = with_stop;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        t = 1; tdone = -1; ndone = 0; hcnt = 0; prev = 1'b0; finished = 0;
        while (t < 20000) begin
            if (t == 1) chk("busy_after_start", busy, n != 0);
            stop = 1'b0;
            if (step_out && !prev) begin
                rises.push_back(t);
                if (stopn > 0 && rises.size() == stopn) stop = 1'b1;
            end
            if (step_out) hcnt++;
            if (!step_out && prev) begin
                chk("pulse_width", hcnt, PW);
                hcnt = 0;
            end
            if (done) begin
                ndone++;
                if (tdone < 0) tdone = t;
            end
            if (busy_start && t == 20) begin
                start = 1'b1; direction = ~d; target_steps = 32'd3;
                period_start = 20'd500; period_min = 20'd500;
            end else begin
                start = 1'b0;
            end
            if (tdone >= 0 && t == tdone + 1) begin
                chk("done_one_cycle", done, 1'b0);
                finished = 1;
                break;
            end
            prev = step_out;
            @(negedge clk);
            t++;
        end
        start = 1'b0; stop = 1'b0;
        chk("move_finished", finished, 1'b1);
        chk("pulse_count", rises.size(), exp_q.size());
        chk("done_count", ndone, 1);
        chk("steps_done", steps_done, exp_q.size());
        chk("busy_idle", busy, 1'b0);
        if (n == 0) chk("zero_done_time", tdone, 1);
        if (n > 0 && rises.size() > 0) begin
            chk("first_rise", rises[0], 1 + DS);
            chk("dir", dir, d);
            for (int i = 0; i + 1 < rises.size() && i + 1 < exp_q.size(); i++)
                chk($sformatf("period[%0d]", i), rises[i+1] - rises[i], exp_q[i]);
            if (rises.size() == exp_q.size())
                chk("period_last", tdone - rises[rises.size()-1], exp_q[exp_q.size()-1]);
        end
    endtask

    initial begin
        int n, ps, pm, sn, t;
        bit seen;
        repeat (2) @(negedge clk);
        chk("rst_step_out", step_out, 1'b0);
        chk("rst_dir", dir, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_steps_done", steps_done, 0);
        rst = 1'b0;

        run_move(5, 40, 40, 1'b1, 0, 0, 0);     // constant rate
        run_move(10, 100, 70, 1'b0, 0, 0, 0);   // trapezoid
        run_move(3, 100, 70, 1'b1, 0, 0, 0);    // triangle
        run_move(100, 100, 70, 1'b1, 6, 0, 0);  // stop during 6th step
        chk("stop_steps", steps_done, 9);
        run_move(0, 50, 50, 1'b0, 0, 0, 0);     // zero-length move
        run_move(3, 3, 3, 1'b0, 0, 0, 0);       // min period clamp
        run_move(6, 60, 30, 1'b1, 0, 1, 0);     // start while busy ignored
        run_move(4, 50, 30, 1'b0, 0, 0, 1);     // start+stop together

        // stop during SETUP
        @(negedge clk);
        target_steps = 32'd5; period_start = 20'd40; period_min = 20'd40; direction = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("setup_stop_done", done, 1'b1);
        chk("setup_stop_busy", busy, 1'b0);
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (step_out) seen = 1;
        end
        chk("setup_stop_no_pulse", seen, 1'b0);
        chk("setup_stop_steps", steps_done, 0);

        // reset mid-pulse
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!step_out && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("reached_pulse", step_out, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_step_out", step_out, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || step_out) seen = 1;
        end
        chk("rst_mid_quiet", seen, 1'b0);

        for (int i = 0; i < 12; i++) begin
            n  = $urandom_range(0, 20);
            ps = $urandom_range(1, 120);
            pm = $urandom_range(1, 120);
            sn = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
            run_move(n, ps, pm, 1'($urandom_range(0, 1)), sn, 0, 0);
        end

`ifdef STEP_POSITION_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("position_reset", position, 0);
        run_move(5, 40, 40, 1'b1, 0, 0, 0);
        run_move(3, 40, 40, 1'b0, 0, 0, 0);
        chk("position", position, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
